// File: rtl/reg_check_monitor.sv
// reg_check_monitor
// Self-check monitor for the MIPS processor top. Keeps a shadow copy of the
// register file by snooping its write port, counts cycles from a start pulse
// and, at programmed checkpoint cycles, compares a shadow register against an
// expected value. Reports pass/fail, mismatch count, first-failure details
// and a timeout abort.
module reg_check_monitor #(
  parameter int  DATA_W     = 32,
  parameter int  ADDR_W     = 5,
  parameter int  NUM_CHECKS = 8,
  parameter int  CYC_W      = 16,
  parameter int  TIMEOUT    = 1000,
  localparam int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int NC_W       = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [CYC_W-1:0]  cfg_cycle,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_exp,
  input  logic [NC_W-1:0]   num_checks,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [NC_W-1:0]   fail_cnt,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_data,
  output logic [CYC_W-1:0]  cycle_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [NC_W-1:0] MAX_CHECKS = NC_W'(NUM_CHECKS);

  // When TIMEOUT does not fit in the cycle counter the counter saturates
  // below it, so the abort compare is disabled entirely.
  localparam bit TIMEOUT_REACHABLE = ($clog2(TIMEOUT + 1) <= CYC_W);
  localparam logic [CYC_W-1:0] TIMEOUT_CNT = CYC_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Shadow register file and checkpoint slots. Both need a full clear on the
  // asynchronous reset, so they are plain flop arrays rather than RAM.
  logic [DATA_W-1:0] shadow_reg     [NUM_REGS];
  logic [CYC_W-1:0]  slot_cycle_reg [NUM_CHECKS];
  logic [ADDR_W-1:0] slot_addr_reg  [NUM_CHECKS];
  logic [DATA_W-1:0] slot_exp_reg   [NUM_CHECKS];

  // Run bookkeeping.
  logic [CYC_W-1:0]  cycle_cnt_reg,  cycle_cnt_next;
  logic [IDX_W-1:0]  ptr_reg,        ptr_next;
  logic [NC_W-1:0]   num_reg,        num_next;
  logic [NC_W-1:0]   fail_cnt_reg,   fail_cnt_next;
  logic              timeout_reg,    timeout_next;
  logic [IDX_W-1:0]  ff_idx_reg,     ff_idx_next;
  logic [DATA_W-1:0] ff_data_reg,    ff_data_next;

  // Current-slot view and derived conditions.
  logic [CYC_W-1:0]  cur_cycle;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_exp;
  logic [DATA_W-1:0] cur_shadow;
  logic              eval_now;
  logic              mismatch;
  logic              ptr_is_last;
  logic              timeout_hit;
  logic [CYC_W-1:0]  cycle_inc;
  logic [NC_W-1:0]   num_clamped;
  logic              cfg_accept;

  // Shadow file follows every processor register write, in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_reg[i] <= '0;
      end
    end else if (wr_en) begin
      shadow_reg[wr_addr] <= wr_data;
    end
  end

  // Slots are only reprogrammable while no run is in flight.
  assign cfg_accept = cfg_we && (state_reg != RUN) && ({1'b0, cfg_idx} < MAX_CHECKS);

  // Checkpoint slot storage, loaded by software through the cfg port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        slot_cycle_reg[i] <= '0;
        slot_addr_reg[i]  <= '0;
        slot_exp_reg[i]   <= '0;
      end
    end else if (cfg_accept) begin
      slot_cycle_reg[cfg_idx] <= cfg_cycle;
      slot_addr_reg[cfg_idx]  <= cfg_addr;
      slot_exp_reg[cfg_idx]   <= cfg_exp;
    end
  end

  assign cur_cycle   = slot_cycle_reg[ptr_reg];
  assign cur_addr    = slot_addr_reg[ptr_reg];
  assign cur_exp     = slot_exp_reg[ptr_reg];
  // Registered shadow value: a write on this same edge is deliberately not seen.
  assign cur_shadow  = shadow_reg[cur_addr];
  assign eval_now    = (state_reg == RUN) && (cycle_cnt_reg >= cur_cycle);
  assign mismatch    = (cur_shadow != cur_exp);
  assign ptr_is_last = ({1'b0, ptr_reg} == (num_reg - NC_W'(1)));
  assign timeout_hit = TIMEOUT_REACHABLE && (cycle_cnt_reg == TIMEOUT_CNT);
  assign cycle_inc   = (&cycle_cnt_reg) ? cycle_cnt_reg : cycle_cnt_reg + CYC_W'(1);
  assign num_clamped = (num_checks > MAX_CHECKS) ? MAX_CHECKS : num_checks;

  // FSM state and run bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cycle_cnt_reg <= '0;
      ptr_reg       <= '0;
      num_reg       <= '0;
      fail_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
      ff_idx_reg    <= '0;
      ff_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cycle_cnt_reg <= cycle_cnt_next;
      ptr_reg       <= ptr_next;
      num_reg       <= num_next;
      fail_cnt_reg  <= fail_cnt_next;
      timeout_reg   <= timeout_next;
      ff_idx_reg    <= ff_idx_next;
      ff_data_reg   <= ff_data_next;
    end
  end

  // Next-state logic: start handling, one slot evaluation per cycle, timeout.
  always_comb begin
    state_next     = state_reg;
    cycle_cnt_next = cycle_cnt_reg;
    ptr_next       = ptr_reg;
    num_next       = num_reg;
    fail_cnt_next  = fail_cnt_reg;
    timeout_next   = timeout_reg;
    ff_idx_next    = ff_idx_reg;
    ff_data_next   = ff_data_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          ptr_next      = '0;
          num_next      = num_clamped;
          fail_cnt_next = '0;
          timeout_next  = 1'b0;
          ff_idx_next   = '0;
          ff_data_next  = '0;
          if (num_clamped == '0) begin
            // Nothing to check: finish immediately as a trivial pass.
            state_next     = DONE;
            cycle_cnt_next = '0;
          end else begin
            state_next     = RUN;
            cycle_cnt_next = CYC_W'(1);
          end
        end
      end

      RUN: begin
        cycle_cnt_next = cycle_inc;
        if (eval_now) begin
          if (mismatch) begin
            fail_cnt_next = fail_cnt_reg + NC_W'(1);
            if (fail_cnt_reg == '0) begin
              ff_idx_next  = ptr_reg;
              ff_data_next = cur_shadow;
            end
          end
        end
        if (eval_now && ptr_is_last) begin
          state_next = DONE;
        end else begin
          if (eval_now) begin
            ptr_next = ptr_reg + IDX_W'(1);
          end
          if (timeout_hit) begin
            // Slots remain pending: abort, freezing the count at TIMEOUT.
            state_next     = DONE;
            timeout_next   = 1'b1;
            cycle_cnt_next = cycle_cnt_reg;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy            = (state_reg == RUN);
  assign done            = (state_reg == DONE);
  assign pass            = done && (fail_cnt_reg == '0) && !timeout_reg;
  assign timeout         = timeout_reg;
  assign fail_cnt        = fail_cnt_reg;
  assign first_fail_idx  = ff_idx_reg;
  assign first_fail_data = ff_data_reg;
  assign cycle_cnt       = cycle_cnt_reg;

endmodule

// File: tb/tb_reg_check_monitor.sv
// tb_reg_check_monitor
// Directed bench for reg_check_monitor with hand-computed expectations.
module tb_reg_check_monitor;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int NUM_CHECKS = 8;
  localparam int CYC_W      = 16;
  localparam int TIMEOUT    = 20;
  localparam int IDX_W      = 3;
  localparam int NC_W       = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_idx = '0;
  logic [CYC_W-1:0]  cfg_cycle = '0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_exp = '0;
  logic [NC_W-1:0]   num_checks = '0;
  logic              start = 1'b0;
  logic              busy, done, pass, timeout;
  logic [NC_W-1:0]   fail_cnt;
  logic [IDX_W-1:0]  first_fail_idx;
  logic [DATA_W-1:0] first_fail_data;
  logic [CYC_W-1:0]  cycle_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  reg_check_monitor #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHECKS(NUM_CHECKS),
    .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_cycle(cfg_cycle),
    .cfg_addr(cfg_addr), .cfg_exp(cfg_exp),
    .num_checks(num_checks), .start(start),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
    .first_fail_data(first_fail_data), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges the bench itself.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = DATA_W'(d);
    tick();
    wr_en   = 1'b0;
    $display("write R%0d = %0d", a, d);
  endtask

  task automatic set_slot(input int idx, input int cyc, input int addr, input int exp);
    cfg_we    = 1'b1;
    cfg_idx   = IDX_W'(idx);
    cfg_cycle = CYC_W'(cyc);
    cfg_addr  = ADDR_W'(addr);
    cfg_exp   = DATA_W'(exp);
    tick();
    cfg_we    = 1'b0;
    $display("slot %0d = {cycle %0d, R%0d, exp %0d}", idx, cyc, addr, exp);
  endtask

  task automatic start_run(input int n);
    num_checks = NC_W'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    $display("start num_checks=%0d", n);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done), 64'(1));
    $display("run ended at cycle_cnt=%0d", cycle_cnt);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    chk("rst_fail_cnt", 64'(fail_cnt), 64'(0));
    chk("rst_ff_idx", 64'(first_fail_idx), 64'(0));
    chk("rst_ff_data", 64'(first_fail_data), 64'(0));
    chk("rst_cycle", 64'(cycle_cnt), 64'(0));
    rst = 1'b0;
    tick();

    // Two slots on the same cycle: evaluated at 9 and 10, done at 11.
    write_reg(0, 16);
    write_reg(1, 0);
    set_slot(0, 9, 0, 16);
    set_slot(1, 9, 1, 0);
    start_run(2);
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_cycle1", 64'(cycle_cnt), 64'(1));
    repeat (2) tick();
    // Reprogramming and restart attempts mid-run must be ignored.
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_cycle = 16'd9; cfg_addr = 5'd1; cfg_exp = 32'd99;
    start  = 1'b1; num_checks = 4'd2;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    chk("t1_no_restart", 64'(cycle_cnt), 64'(4));
    repeat (6) tick();
    chk("t1_cycle10", 64'(cycle_cnt), 64'(10));
    chk("t1_busy10", 64'(busy), 64'(1));
    tick();
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_busy_fall", 64'(busy), 64'(0));
    chk("t1_cycle11", 64'(cycle_cnt), 64'(11));
    chk("t1_pass", 64'(pass), 64'(1));
    chk("t1_fail_cnt", 64'(fail_cnt), 64'(0));

    // Slot1 expectation wrong: single mismatch at slot 1, shadow value 0.
    set_slot(1, 9, 1, 5);
    start_run(2);
    repeat (9) tick();
    chk("t2_fail_before", 64'(fail_cnt), 64'(0));
    tick();
    chk("t2_done", 64'(done), 64'(1));
    chk("t2_pass", 64'(pass), 64'(0));
    chk("t2_fail_cnt", 64'(fail_cnt), 64'(1));
    chk("t2_ff_idx", 64'(first_fail_idx), 64'(1));
    chk("t2_ff_data", 64'(first_fail_data), 64'(0));

    // Same-cycle write is invisible; the check one cycle later sees it.
    set_slot(0, 5, 3, 7);
    set_slot(1, 6, 3, 7);
    start_run(2);
    repeat (4) tick();
    chk("t3_cycle5", 64'(cycle_cnt), 64'(5));
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd7;
    tick();
    wr_en = 1'b0;
    chk("t3_fail_after_c5", 64'(fail_cnt), 64'(1));
    tick();
    chk("t3_done", 64'(done), 64'(1));
    chk("t3_fail_cnt", 64'(fail_cnt), 64'(1));
    chk("t3_ff_idx", 64'(first_fail_idx), 64'(0));
    chk("t3_ff_data", 64'(first_fail_data), 64'(0));
    chk("t3_pass", 64'(pass), 64'(0));

    // Checkpoint beyond TIMEOUT: abort at cycle_cnt 20.
    set_slot(0, 50, 0, 16);
    start_run(1);
    wait_done(40);
    chk("t4_cycle", 64'(cycle_cnt), 64'(20));
    chk("t4_timeout", 64'(timeout), 64'(1));
    chk("t4_pass", 64'(pass), 64'(0));
    chk("t4_fail_cnt", 64'(fail_cnt), 64'(0));

    // Zero checks: immediate trivial pass; then a fresh run from DONE.
    start_run(0);
    chk("t5_done", 64'(done), 64'(1));
    chk("t5_pass", 64'(pass), 64'(1));
    chk("t5_timeout_clr", 64'(timeout), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    set_slot(0, 3, 0, 16);
    start_run(1);
    chk("t5b_busy", 64'(busy), 64'(1));
    chk("t5b_done", 64'(done), 64'(0));
    chk("t5b_cycle", 64'(cycle_cnt), 64'(1));
    wait_done(10);
    chk("t5b_pass", 64'(pass), 64'(1));
    chk("t5b_cycle_end", 64'(cycle_cnt), 64'(4));

    // Asynchronous reset in the middle of a run.
    set_slot(0, 9, 0, 16);
    start_run(1);
    repeat (4) tick();
    chk("t6_cycle5", 64'(cycle_cnt), 64'(5));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_done", 64'(done), 64'(0));
    chk("t6_cycle", 64'(cycle_cnt), 64'(0));
    chk("t6_pass", 64'(pass), 64'(0));
    tick();
    rst = 1'b0;
    $display("reset pulse applied mid-run");
    // Shadow R0 was cleared, so a check for 0 must pass.
    set_slot(0, 3, 0, 0);
    start_run(1);
    wait_done(10);
    chk("t6b_pass", 64'(pass), 64'(1));
    chk("t6b_fail_cnt", 64'(fail_cnt), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
